// File: rtl/busdispatch_pkg.sv
// Shared types and constants for the timed wishbone request router.
package busdispatch_pkg;

  // Router FSM: waiting for a request, waiting on a slave, returning the response.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Default region map, slice i is slave i's region: {slave3, slave2, slave1, slave0}.
  localparam logic [11:0] DEFAULT_SLAVE_MAP = {3'h7, 3'h3, 3'h2, 3'h1};

  // Read value returned for unmapped or timed-out accesses.
  localparam int ERR_RDATA = 0;

  // Width of the ACTIVE-state timeout counter; holds TIMEOUT-1 for TIMEOUT up to 255.
  localparam int TCNT_W = 8;

  // Terminal count of the timeout counter for a given TIMEOUT.
  function automatic logic [TCNT_W-1:0] timeout_last(input int timeout);
    return TCNT_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/wb_region_decode.sv
// Combinational region decoder: priority match of an address region against the
// packed slave map. The lowest matching slave index wins, so duplicate map
// entries are legal and simply shadow the higher slaves.
module wb_region_decode #(
  parameter int                         NSLAVES   = 4,
  parameter int                         SEL_W     = 3,
  parameter int                         IDX_W     = 2,
  parameter logic [NSLAVES*SEL_W-1:0]   SLAVE_MAP = '0
) (
  input  logic [SEL_W-1:0] region,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the highest slave down so the lowest matching index is left last.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it
    // unassigned and no latch is inferred.
    hit = 1'b0;
    idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (SLAVE_MAP[i*SEL_W +: SEL_W] == region) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/busdispatch_timed.sv
// Timed wishbone request router: one requester, NSLAVES peripherals chosen by
// the upper address bits. Unmapped accesses and slaves that fail to ack within
// TIMEOUT cycles are completed here with zero read data and err_o, so a missing
// or hung peripheral can never stall the requester.
module busdispatch_timed
  import busdispatch_pkg::*;
#(
  parameter int                       NSLAVES   = 4,
  parameter int                       ADDR_W    = 7,
  parameter int                       SEL_W     = 3,
  parameter int                       DATA_W    = 32,
  parameter logic [NSLAVES*SEL_W-1:0] SLAVE_MAP = DEFAULT_SLAVE_MAP,
  parameter int                       TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  // requester side
  input  logic                      wb_stb_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_we_i,
  input  logic [ADDR_W-1:0]         wb_adr_i,
  input  logic [DATA_W-1:0]         wb_dat_i,
  output logic [DATA_W-1:0]         wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      err_o,
  // slave side
  output logic [NSLAVES-1:0]        s_wb_stb_o,
  output logic                      s_wb_cyc_o,
  output logic                      s_wb_we_o,
  output logic [ADDR_W-SEL_W-1:0]   s_wb_adr_o,
  output logic [DATA_W-1:0]         s_wb_dat_o,
  input  logic [NSLAVES*DATA_W-1:0] s_wb_dat_i,
  input  logic [NSLAVES-1:0]        s_wb_ack_i,
  // error bookkeeping
  output logic [15:0]               err_cnt_o,
  output logic [ADDR_W-1:0]         err_adr_o
);

  localparam int IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int LOW_W = ADDR_W - SEL_W;
  localparam logic [TCNT_W-1:0] TCNT_LAST = timeout_last(TIMEOUT);
  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // Reject parameter sets the datapath cannot represent.
  if (NSLAVES < 1 || NSLAVES > 8) begin : g_bad_nslaves
    $error("busdispatch_timed: NSLAVES must be 1..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("busdispatch_timed: TIMEOUT must be 1..255");
  end
  if (SEL_W < 1 || SEL_W >= ADDR_W) begin : g_bad_sel_w
    $error("busdispatch_timed: SEL_W must be 1..ADDR_W-1");
  end

  state_t              state;
  logic [IDX_W-1:0]    sel;
  logic [TCNT_W-1:0]   tcnt;
  logic [15:0]         err_cnt_q;

  logic [SEL_W-1:0]    region;
  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_dat;
  logic                req;

  assign region  = wb_adr_i[ADDR_W-1 -: SEL_W];
  assign req     = wb_stb_i & wb_cyc_i;
  assign sel_ack = s_wb_ack_i[sel];
  assign sel_dat = s_wb_dat_i[sel*DATA_W +: DATA_W];

  wb_region_decode #(
    .NSLAVES   (NSLAVES),
    .SEL_W     (SEL_W),
    .IDX_W     (IDX_W),
    .SLAVE_MAP (SLAVE_MAP)
  ) u_decode (
    .region (region),
    .hit    (dec_hit),
    .idx    (dec_idx)
  );

  // Cycle, direction, low address and write data go to every slave unchanged;
  // only the strobe is steered.
  assign s_wb_cyc_o = wb_cyc_i;
  assign s_wb_we_o  = wb_we_i;
  assign s_wb_adr_o = wb_adr_i[LOW_W-1:0];
  assign s_wb_dat_o = wb_dat_i;
  assign err_cnt_o  = err_cnt_q;

  // Steer the requester strobe to the latched slave while a transfer is active;
  // gating by wb_stb_i drops it immediately when the requester withdraws.
  always_comb begin
    s_wb_stb_o = '0;
    if (state == ST_ACTIVE) begin
      s_wb_stb_o[sel] = wb_stb_i;
    end
  end

  // Router FSM with registered ack/err/data and error bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= ST_IDLE;
      sel       <= '0;
      tcnt      <= '0;
      wb_ack_o  <= 1'b0;
      err_o     <= 1'b0;
      wb_dat_o  <= '0;
      err_cnt_q <= '0;
      err_adr_o <= '0;
    end else begin
      // ack and err are single-cycle pulses unless a branch below raises them
      wb_ack_o <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (dec_hit) begin
              sel   <= dec_idx;
              tcnt  <= '0;
              state <= ST_ACTIVE;
            end else begin
              err_adr_o <= wb_adr_i;
              wb_dat_o  <= DATA_W'(ERR_RDATA);
              wb_ack_o  <= 1'b1;
              err_o     <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end

        ST_ACTIVE: begin
          if (!wb_cyc_i) begin
            // requester abandoned the cycle: no response, no error count
            state <= ST_IDLE;
          end else if (sel_ack) begin
            // an ack on the final allowed cycle still beats the timeout
            wb_dat_o <= sel_dat;
            wb_ack_o <= 1'b1;
            state    <= ST_RESP;
          end else if (tcnt == TCNT_LAST) begin
            err_adr_o <= wb_adr_i;
            wb_dat_o  <= DATA_W'(ERR_RDATA);
            wb_ack_o  <= 1'b1;
            err_o     <= 1'b1;
            state     <= ST_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_RESP: begin
          if (err_o && err_cnt_q != ERR_CNT_MAX) begin
            err_cnt_q <= err_cnt_q + 16'd1;
          end
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_busdispatch_timed.sv
// Self-checking bench for busdispatch_timed: a table of directed transfers run
// through one driver task, plus hand-written abort, reset and saturation sequences.
module tb_busdispatch_timed;

  localparam int NS  = 4;
  localparam int AW  = 7;
  localparam int SW  = 3;
  localparam int DW  = 32;
  localparam int TO  = 15;

  logic              clk;
  logic              rst;
  logic              wb_stb_i;
  logic              wb_cyc_i;
  logic              wb_we_i;
  logic [AW-1:0]     wb_adr_i;
  logic [DW-1:0]     wb_dat_i;
  logic [DW-1:0]     wb_dat_o;
  logic              wb_ack_o;
  logic              err_o;
  logic [NS-1:0]     s_wb_stb_o;
  logic              s_wb_cyc_o;
  logic              s_wb_we_o;
  logic [AW-SW-1:0]  s_wb_adr_o;
  logic [DW-1:0]     s_wb_dat_o;
  logic [NS*DW-1:0]  s_wb_dat_i;
  logic [NS-1:0]     s_wb_ack_i;
  logic [15:0]       err_cnt_o;
  logic [AW-1:0]     err_adr_o;

  busdispatch_timed #(
    .NSLAVES   (NS),
    .ADDR_W    (AW),
    .SEL_W     (SW),
    .DATA_W    (DW),
    .SLAVE_MAP ({3'h7, 3'h3, 3'h2, 3'h1}),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .err_o      (err_o),
    .s_wb_stb_o (s_wb_stb_o),
    .s_wb_cyc_o (s_wb_cyc_o),
    .s_wb_we_o  (s_wb_we_o),
    .s_wb_adr_o (s_wb_adr_o),
    .s_wb_dat_o (s_wb_dat_o),
    .s_wb_dat_i (s_wb_dat_i),
    .s_wb_ack_i (s_wb_ack_i),
    .err_cnt_o  (err_cnt_o),
    .err_adr_o  (err_adr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed transfer: stimulus plus hand-computed expectations.
  // ack_at is the strobe cycle (1-based after the request cycle) in which the
  // slaves in ack_mask assert ack; 0 means nobody acks.
  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] wdat;
    logic [NS-1:0] ack_mask;
    int            ack_at;
    logic [DW-1:0] rdat;
    int            exp_slave;   // -1: no slave may be strobed
    int            exp_cycle;   // cycle in which wb_ack_o is seen
    logic          exp_err;
    logic [DW-1:0] exp_dat;
    int            exp_stb;     // strobe cycles on exp_slave
  } vec_t;

  int          checks;
  int          failures;
  logic [15:0] exp_err_cnt;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    wb_stb_i   = 1'b0;
    wb_cyc_i   = 1'b0;
    wb_we_i    = 1'b0;
    s_wb_ack_i = '0;
  endtask

  // Runs one transfer starting #1 after a rising edge; ends #1 after an edge.
  task automatic run_vec(input vec_t v, input int id);
    int            n;
    int            stb_cnt;
    bit            other_stb;
    bit            got;
    logic [NS-1:0] exp_mask;
    string         tag;
    tag       = $sformatf("v%0d", id);
    exp_mask  = (v.exp_slave >= 0) ? NS'(1) << v.exp_slave : '0;
    for (int i = 0; i < NS; i++) begin
      s_wb_dat_i[i*DW +: DW] = (i == v.exp_slave) ? v.rdat : (32'hBAD0_0000 | 32'(i));
    end
    wb_adr_i   = v.adr;
    wb_we_i    = v.we;
    wb_dat_i   = v.wdat;
    wb_stb_i   = 1'b1;
    wb_cyc_i   = 1'b1;
    s_wb_ack_i = '0;
    #1;
    check({tag, "_bcast_adr"}, DW'(s_wb_adr_o), DW'(v.adr[AW-SW-1:0]));
    check({tag, "_bcast_we_dat"}, {s_wb_we_o, s_wb_cyc_o, s_wb_dat_o[29:0]},
          {v.we, 1'b1, v.wdat[29:0]});
    check({tag, "_idle_no_stb"}, DW'(s_wb_stb_o), 32'd0);
    got       = 1'b0;
    n         = 0;
    stb_cnt   = 0;
    other_stb = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      s_wb_ack_i = (n == v.ack_at) ? v.ack_mask : '0;
      if (v.exp_slave >= 0 && s_wb_stb_o[v.exp_slave]) stb_cnt++;
      if ((s_wb_stb_o & ~exp_mask) != '0) other_stb = 1'b1;
      if (wb_ack_o) got = 1'b1;
    end
    if (!got) begin
      check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_ack_cycle"}, 32'(n), 32'(v.exp_cycle));
      check({tag, "_err"}, DW'(err_o), DW'(v.exp_err));
      check({tag, "_rdat"}, wb_dat_o, v.exp_dat);
      if (v.exp_err) check({tag, "_err_adr"}, DW'(err_adr_o), DW'(v.adr));
    end
    check({tag, "_stb_cycles"}, 32'(stb_cnt), 32'(v.exp_stb));
    check({tag, "_stray_stb"}, DW'(other_stb), 32'd0);
    idle_bus();
    if (v.exp_err && exp_err_cnt != 16'hFFFF) exp_err_cnt = exp_err_cnt + 16'd1;
    @(posedge clk);
    #1;
    check({tag, "_ack_single"}, DW'({wb_ack_o, err_o}), 32'd0);
    check({tag, "_rdat_hold"}, wb_dat_o, v.exp_dat);
    check({tag, "_err_cnt"}, DW'(err_cnt_o), DW'(exp_err_cnt));
  endtask

  // Watches for any ack over a window where none is allowed.
  task automatic expect_quiet(input string name, input int cycles);
    int acks;
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o) acks++;
    end
    check(name, 32'(acks), 32'd0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_err_cnt = 16'd0;

    //           adr    we    wdat           mask    at  rdat           slv cyc err  exp_dat        stb
    vecs[0] = '{7'h25, 1'b0, 32'h0,         4'b0010, 3, 32'h1234_5678,  1,  4, 1'b0, 32'h1234_5678,  3};
    vecs[1] = '{7'h40, 1'b0, 32'h0,         4'b0000, 0, 32'h0,         -1,  1, 1'b1, 32'h0,          0};
    vecs[2] = '{7'h3A, 1'b0, 32'h0,         4'b0000, 0, 32'h5555_AAAA,  2, 16, 1'b1, 32'h0,         15};
    vecs[3] = '{7'h3A, 1'b0, 32'h0,         4'b0100, 15, 32'hCAFE_F00D, 2, 16, 1'b0, 32'hCAFE_F00D, 15};
    vecs[4] = '{7'h1F, 1'b0, 32'h0,         4'b0001, 1, 32'hA5A5_5A5A,  0,  2, 1'b0, 32'hA5A5_5A5A,  1};
    vecs[5] = '{7'h7E, 1'b1, 32'h1122_3344, 4'b1000, 1, 32'h0000_BEEF,  3,  2, 1'b0, 32'h0000_BEEF,  1};
    vecs[6] = '{7'h2C, 1'b0, 32'h0,         4'b0001, 2, 32'h7777_7777,  1, 16, 1'b1, 32'h0,         15};
    vecs[7] = '{7'h05, 1'b0, 32'h0,         4'b0000, 0, 32'h0,         -1,  1, 1'b1, 32'h0,          0};
    vecs[8] = '{7'h6F, 1'b1, 32'hFFFF_0000, 4'b0000, 0, 32'h0,         -1,  1, 1'b1, 32'h0,          0};

    // reset state
    rst        = 1'b1;
    wb_adr_i   = '0;
    wb_dat_i   = '0;
    s_wb_dat_i = '0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack_err", DW'({wb_ack_o, err_o}), 32'd0);
    check("rst_rdat", wb_dat_o, 32'd0);
    check("rst_stb", DW'(s_wb_stb_o), 32'd0);
    check("rst_err_cnt_adr", DW'({err_cnt_o, err_adr_o}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // table-driven transfers
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // abort: cyc dropped while ACTIVE
    wb_adr_i = 7'h25;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    @(posedge clk);
    #1;
    check("abort_stb_active", DW'(s_wb_stb_o), 32'b0010);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    #1;
    check("abort_stb_gated", DW'(s_wb_stb_o), 32'd0);
    expect_quiet("abort_no_ack", 20);
    check("abort_err_cnt", DW'(err_cnt_o), DW'(exp_err_cnt));
    run_vec(vecs[0], 100);

    // synchronous reset while ACTIVE drops the transfer and clears counters
    wb_adr_i = 7'h3A;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstact_stb_active", DW'(s_wb_stb_o), 32'b0100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_bus();
    exp_err_cnt = 16'd0;
    check("rstact_cleared", DW'({wb_ack_o, err_o, s_wb_stb_o}), 32'd0);
    check("rstact_err_state", DW'({err_cnt_o, err_adr_o}), 32'd0);
    check("rstact_rdat", wb_dat_o, 32'd0);
    expect_quiet("rstact_no_ack", 20);
    run_vec(vecs[4], 101);

    // saturation: preload the error counter just below its ceiling
    force dut.err_cnt_q = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.err_cnt_q;
    exp_err_cnt = 16'hFFFD;
    run_vec(vecs[1], 200);
    run_vec(vecs[7], 201);
    run_vec(vecs[8], 202);
    check("sat_final", DW'(err_cnt_o), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
